count_seg_display: RTL

Downstream display stage for the 4-bit bit counter. It registers the counter value and converts it to two decimal digits, 00–15, with the tens digit blanked for values 0–9. It time-multiplexes the two digits onto a shared seven-segment bus and flags every 15→0 wrap of the counter with a one-cycle pulse and a 4-bit wrap tally. It runs on the same clock and reset as the bit counter that feeds it.

---
 rtl/count_seg_display.sv | 102 ++++++++++
 1 files changed

// File: rtl/count_seg_display.sv
// Display stage for the 4-bit bit counter: registers the count, splits it into two
// decimal digits, multiplexes them onto one seven-segment bus and tallies 15->0 wraps.

// Seven-segment decoder for one digit; codes above 9 render blank.
module count_seg_digit (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0000000;
        case (digit)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end
endmodule

module count_seg_display #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] counter,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap,
    output logic [3:0] wraps
);
    localparam int NUM_DIGITS = 2;
    localparam int DIV_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic {UNITS, TENS} state_t;

    state_t     state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [3:0] cnt_q;
    logic       wrap_set;

    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][6:0] digit_seg;

    assign wrap_set = (cnt_q == 4'd15) && (counter == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
            state <= UNITS;
            div   <= '0;
            wrap  <= 1'b0;
            wraps <= 4'd0;
        end else begin
            cnt_q <= counter;
            state <= state_nxt;
            div   <= div_nxt;
            wrap  <= wrap_set;
            if (wrap_set)
                wraps <= wraps + 4'd1;
        end
    end

    // Tens digit only ever shows 1; the blank code keeps the decoder output dark for 0..9.
    always_comb begin
        digits[0] = (cnt_q >= 4'd10) ? cnt_q - 4'd10 : cnt_q;
        digits[1] = (cnt_q >= 4'd10) ? 4'd1 : BLANK;
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
            count_seg_digit u_dec (
                .digit (digits[g]),
                .seg   (digit_seg[g])
            );
        end
    endgenerate

    // an and seg both come from state, so the digit switch is glitch-free per cycle.
    always_comb begin
        state_nxt = state;
        div_nxt   = div + 1'b1;
        an        = 2'b01;
        seg       = digit_seg[0];
        if (div == DIV_LAST) begin
            div_nxt   = '0;
            state_nxt = (state == UNITS) ? TENS : UNITS;
        end
        if (state == TENS) begin
            an  = 2'b10;
            seg = digit_seg[1];
        end
    end
endmodule
